// File: rtl/scl_pix_packer.sv
// scl_pix_packer
//   Packs the three scaled gray pixel streams (1/1, 1/2, 1/4) into 32-bit words, four pixels
//   per word with the first pixel in byte lane 0. Each scale has its own base address, word
//   counter and two-entry word FIFO. A two-state FSM drains the FIFOs round-robin
//   (1 -> 2 -> 4 -> 1) over a req/ack write port.
// Ports
//   tm3_clk_v0            clock, rising edge
//   rst_n                 asynchronous active-low reset
//   vidin_new_data_scld_* pixel strobe per scale
//   vidin_gray_scld_*     8-bit pixel per scale
//   frame_start           one-cycle pulse, restarts pixel and word counters of all scales
//   ovf_clr               clears the sticky overflow flags (a new overflow wins)
//   wr_req/wr_ack         write handshake, transfer = wr_req & wr_ack
//   wr_addr/wr_data       word address and packed word, stable while wr_req=1
//   ovf                   sticky overflow flags {scale4, scale2, scale1}
module scl_pix_packer #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BASE_1  = 0,
  parameter int unsigned BASE_2  = 19200,
  parameter int unsigned BASE_4  = 24000,
  parameter int unsigned WORDS_1 = 19200,
  parameter int unsigned WORDS_2 = 4800,
  parameter int unsigned WORDS_4 = 1200
) (
  input  logic              tm3_clk_v0,
  input  logic              rst_n,
  input  logic              vidin_new_data_scld_1,
  input  logic              vidin_new_data_scld_2,
  input  logic              vidin_new_data_scld_4,
  input  logic [7:0]        vidin_gray_scld_1,
  input  logic [7:0]        vidin_gray_scld_2,
  input  logic [7:0]        vidin_gray_scld_4,
  input  logic              frame_start,
  input  logic              ovf_clr,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ack,
  output logic [2:0]        ovf
);

  localparam logic [2:0][ADDR_W-1:0] Base = {ADDR_W'(BASE_4), ADDR_W'(BASE_2), ADDR_W'(BASE_1)};
  localparam logic [2:0][ADDR_W-1:0] Last = {ADDR_W'(WORDS_4 - 1), ADDR_W'(WORDS_2 - 1),
                                             ADDR_W'(WORDS_1 - 1)};

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  logic [2:0]       strobe;
  logic [2:0][7:0]  gray;

  assign strobe = {vidin_new_data_scld_4, vidin_new_data_scld_2, vidin_new_data_scld_1};
  assign gray   = {vidin_gray_scld_4, vidin_gray_scld_2, vidin_gray_scld_1};

  // Packing stage: a completed word is held for one cycle in pend_* before entering its FIFO.
  logic [2:0][1:0]        pix_cnt_q;
  logic [2:0][23:0]       lanes_q;
  logic [2:0][ADDR_W-1:0] word_cnt_q;
  logic [2:0]             pend_vld_q;
  logic [2:0][31:0]       pend_data_q;
  logic [2:0][ADDR_W-1:0] pend_addr_q;

  always_ff @(posedge tm3_clk_v0 or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q   <= '0;
      lanes_q     <= '0;
      word_cnt_q  <= '0;
      pend_vld_q  <= '0;
      pend_data_q <= '0;
      pend_addr_q <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        pend_vld_q[k] <= 1'b0;
        if (frame_start) begin
          // Partial word is abandoned; a coincident pixel starts the new frame in lane 0.
          word_cnt_q[k] <= '0;
          pix_cnt_q[k]  <= strobe[k] ? 2'd1 : 2'd0;
          if (strobe[k]) lanes_q[k][7:0] <= gray[k];
        end else if (strobe[k]) begin
          pix_cnt_q[k] <= pix_cnt_q[k] + 2'd1;
          case (pix_cnt_q[k])
            2'd0: lanes_q[k][7:0]   <= gray[k];
            2'd1: lanes_q[k][15:8]  <= gray[k];
            2'd2: lanes_q[k][23:16] <= gray[k];
            default: begin
              pend_vld_q[k]  <= 1'b1;
              pend_data_q[k] <= {gray[k], lanes_q[k]};
              pend_addr_q[k] <= Base[k] + word_cnt_q[k];
              word_cnt_q[k]  <= (word_cnt_q[k] == Last[k]) ? '0
                                                           : word_cnt_q[k] + ADDR_W'(1);
            end
          endcase
        end
      end
    end
  end

  // Per-scale two-entry FIFOs. The head stays in the FIFO until its write is acknowledged.
  logic [2:0][1:0][31:0]       fifo_data_q;
  logic [2:0][1:0][ADDR_W-1:0] fifo_addr_q;
  logic [2:0]                  fifo_wp_q;
  logic [2:0]                  fifo_rp_q;
  logic [2:0][1:0]             fifo_cnt_q;
  logic [2:0]                  push;
  logic [2:0]                  pop;
  logic [2:0]                  drop;
  logic [2:0]                  ovf_q;

  state_e            state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        sel_q, sel_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  always_comb begin
    push = '0;
    pop  = '0;
    drop = '0;
    for (int k = 0; k < 3; k++) begin
      // Full check uses the count before any same-cycle pop.
      push[k] = pend_vld_q[k] && (fifo_cnt_q[k] != 2'd2);
      drop[k] = pend_vld_q[k] && (fifo_cnt_q[k] == 2'd2);
      pop[k]  = (state_q == StReq) && wr_ack && (sel_q == 2'(k));
    end
  end

  always_ff @(posedge tm3_clk_v0 or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q <= '0;
      fifo_addr_q <= '0;
      fifo_wp_q   <= '0;
      fifo_rp_q   <= '0;
      fifo_cnt_q  <= '0;
      ovf_q       <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (push[k]) begin
          fifo_data_q[k][fifo_wp_q[k]] <= pend_data_q[k];
          fifo_addr_q[k][fifo_wp_q[k]] <= pend_addr_q[k];
          fifo_wp_q[k]                 <= ~fifo_wp_q[k];
        end
        if (pop[k]) fifo_rp_q[k] <= ~fifo_rp_q[k];
        fifo_cnt_q[k] <= fifo_cnt_q[k] + {1'b0, push[k]} - {1'b0, pop[k]};
      end
      ovf_q <= (ovf_clr ? 3'b000 : ovf_q) | drop;
    end
  end

  // Round-robin pick: first non-empty FIFO starting at rr_q.
  logic       found;
  logic [1:0] pick;
  logic [2:0] sum;
  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < 3; i++) begin
      sum  = {1'b0, rr_q} + 3'(i);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && (fifo_cnt_q[cand] != 2'd0)) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d   = StReq;
          sel_d     = pick;
          rr_d      = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          wr_req_d  = 1'b1;
          wr_addr_d = fifo_addr_q[pick][fifo_rp_q[pick]];
          wr_data_d = fifo_data_q[pick][fifo_rp_q[pick]];
        end
      end
      StReq: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge tm3_clk_v0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      sel_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_req  = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_scl_pix_packer.sv
// Testbench for scl_pix_packer: directed scenarios plus a randomized phase, all checked against
// a transaction-level model of the per-scale word lists.
module tb_scl_pix_packer;

  logic        tm3_clk_v0 = 1'b0;
  logic        rst_n = 1'b0;
  logic        vidin_new_data_scld_1 = 1'b0;
  logic        vidin_new_data_scld_2 = 1'b0;
  logic        vidin_new_data_scld_4 = 1'b0;
  logic [7:0]  vidin_gray_scld_1 = '0;
  logic [7:0]  vidin_gray_scld_2 = '0;
  logic [7:0]  vidin_gray_scld_4 = '0;
  logic        frame_start = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        wr_ack = 1'b0;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  ovf;

  always #5 tm3_clk_v0 = ~tm3_clk_v0;

  scl_pix_packer dut (
    .tm3_clk_v0            (tm3_clk_v0),
    .rst_n                 (rst_n),
    .vidin_new_data_scld_1 (vidin_new_data_scld_1),
    .vidin_new_data_scld_2 (vidin_new_data_scld_2),
    .vidin_new_data_scld_4 (vidin_new_data_scld_4),
    .vidin_gray_scld_1     (vidin_gray_scld_1),
    .vidin_gray_scld_2     (vidin_gray_scld_2),
    .vidin_gray_scld_4     (vidin_gray_scld_4),
    .frame_start           (frame_start),
    .ovf_clr               (ovf_clr),
    .wr_req                (wr_req),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .wr_ack                (wr_ack),
    .ovf                   (ovf)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference model: per scale, the words waiting to be written (at most two), in order.
  int          base_a[3]  = '{0, 19200, 24000};
  int          words_a[3] = '{19200, 4800, 1200};
  int          m_pix[3];
  int          m_wcnt[3];
  logic [31:0] m_word[3];
  bit          pend_v[3];
  int          pend_a[3];
  logic [31:0] pend_d[3];
  int          m_n[3];
  int          m_fa[3][2];
  logic [31:0] m_fd[3][2];
  logic [2:0]  exp_ovf;

  int          log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          cyc;
  int          req_cycles;
  int          first_req_cyc;
  logic        prev_req;

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_pix[s] = 0; m_wcnt[s] = 0; m_word[s] = '0;
      pend_v[s] = 0; m_n[s] = 0;
    end
    exp_ovf  = '0;
    prev_req = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    req_cycles = 0; first_req_cyc = -1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance the model to
  // the state after the next rising edge.
  task automatic step(input logic [2:0] stb, input logic [7:0] p1, input logic [7:0] p2,
                      input logic [7:0] p4, input logic fs, input logic clr, input logic ack);
    logic [7:0] px[3];
    bit         popf[3];
    logic [2:0] drops;
    int         s;
    @(negedge tm3_clk_v0);
    vidin_new_data_scld_1 = stb[0]; vidin_gray_scld_1 = p1;
    vidin_new_data_scld_2 = stb[1]; vidin_gray_scld_2 = p2;
    vidin_new_data_scld_4 = stb[2]; vidin_gray_scld_4 = p4;
    frame_start = fs; ovf_clr = clr; wr_ack = ack;
    px[0] = p1; px[1] = p2; px[2] = p4;
    popf = '{0, 0, 0};
    drops = '0;
    check("ovf", {29'b0, ovf}, {29'b0, exp_ovf});
    if (wr_req) begin
      req_cycles++;
      if (!prev_req && first_req_cyc < 0) first_req_cyc = cyc;
    end
    prev_req = wr_req;
    if (wr_req && ack) begin
      s = (wr_addr < 19200) ? 0 : ((wr_addr < 24000) ? 1 : 2);
      check("queued_word_exists", 32'(m_n[s] != 0), 32'd1);
      if (m_n[s] != 0) begin
        check("wr_addr", {16'b0, wr_addr}, m_fa[s][0]);
        check("wr_data", wr_data, m_fd[s][0]);
        popf[s] = 1;
      end
      log_addr.push_back(int'(wr_addr)); log_data.push_back(wr_data); log_cyc.push_back(cyc);
    end
    for (int k = 0; k < 3; k++) begin
      bit full;
      full = (m_n[k] == 2);
      if (popf[k]) begin
        m_fa[k][0] = m_fa[k][1]; m_fd[k][0] = m_fd[k][1]; m_n[k]--;
      end
      if (pend_v[k]) begin
        if (full) drops[k] = 1'b1;
        else begin
          m_fa[k][m_n[k]] = pend_a[k]; m_fd[k][m_n[k]] = pend_d[k]; m_n[k]++;
        end
      end
      pend_v[k] = 0;
      if (fs) begin
        m_pix[k] = 0; m_wcnt[k] = 0; m_word[k] = '0;
      end
      if (stb[k]) begin
        m_word[k] = m_word[k] | (32'(px[k]) << (8 * m_pix[k]));
        m_pix[k]++;
        if (m_pix[k] == 4) begin
          pend_v[k] = 1; pend_a[k] = base_a[k] + m_wcnt[k]; pend_d[k] = m_word[k];
          m_word[k] = '0; m_pix[k] = 0;
          m_wcnt[k] = (m_wcnt[k] + 1) % words_a[k];
        end
      end
    end
    exp_ovf = (clr ? 3'b000 : exp_ovf) | drops;
    cyc++;
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(3'b000, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0, ack);
  endtask

  task automatic do_reset();
    @(negedge tm3_clk_v0);
    rst_n = 1'b0;
    model_reset();
    @(negedge tm3_clk_v0);
    @(negedge tm3_clk_v0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1500us;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  n0;
    bit  seen;
    int  ack_pct;
    cyc = 0;
    model_reset();
    clear_log();
    repeat (3) @(negedge tm3_clk_v0);
    rst_n = 1'b1;
    check("rst_wr_req", {31'b0, wr_req}, 32'd0);
    check("rst_wr_addr", {16'b0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_ovf", {29'b0, ovf}, 32'd0);

    // 1: single word, latency and one-cycle request with ack tied high
    clear_log();
    step(3'b001, 8'h11, 0, 0, 0, 0, 1);
    step(3'b001, 8'h22, 0, 0, 0, 0, 1);
    step(3'b001, 8'h33, 0, 0, 0, 0, 1);
    n0 = cyc;
    step(3'b001, 8'h44, 0, 0, 0, 0, 1);
    idle(8, 1);
    check("t1_count", log_addr.size(), 1);
    if (log_addr.size() >= 1) begin
      check("t1_addr", log_addr[0], 0);
      check("t1_data", log_data[0], 32'h44332211);
    end
    check("t1_req_cycles", req_cycles, 1);
    check("t1_latency", first_req_cyc - n0, 3);

    // 2: frame_start discards a partial word
    clear_log();
    step(3'b001, 8'h55, 0, 0, 1, 0, 1);
    step(3'b001, 8'h66, 0, 0, 0, 0, 1);
    step(3'b001, 8'h77, 0, 0, 0, 0, 1);
    step(3'b000, 8'h00, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(3'b001, 8'hA0 + 8'(i), 0, 0, 0, 0, 1);
    idle(8, 1);
    check("t2_count", log_addr.size(), 1);
    if (log_addr.size() >= 1) begin
      check("t2_addr", log_addr[0], 0);
      check("t2_data", log_data[0], 32'hA3A2A1A0);
    end

    // 3: all scales complete together; round-robin from scale 1 after reset
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) step(3'b111, 8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 0, 0, 1);
    idle(12, 1);
    check("t3_count", log_addr.size(), 3);
    if (log_addr.size() >= 3) begin
      check("t3_addr0", log_addr[0], 0);
      check("t3_addr1", log_addr[1], 19200);
      check("t3_addr2", log_addr[2], 24000);
      check("t3_gap01", log_cyc[1] - log_cyc[0], 2);
      check("t3_gap12", log_cyc[2] - log_cyc[1], 2);
    end

    // 4: overflow while the port is stalled
    step(3'b000, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 12; i++) step(3'b001, 8'(i), 0, 0, 0, 0, 0);
    idle(4, 0);
    check("t4_ovf_set", {29'b0, ovf}, 32'd1);
    clear_log();
    idle(10, 1);
    check("t4_count", log_addr.size(), 2);
    if (log_addr.size() >= 2) begin
      check("t4_addr0", log_addr[0], 0);
      check("t4_addr1", log_addr[1], 1);
    end
    for (int i = 0; i < 4; i++) step(3'b001, 8'hC0 + 8'(i), 0, 0, 0, 0, 1);
    idle(8, 1);
    check("t4_count_next", log_addr.size(), 3);
    if (log_addr.size() >= 3) check("t4_addr_next", log_addr[2], 3);
    step(3'b000, 0, 0, 0, 0, 1, 1);
    idle(1, 1);
    check("t4_ovf_clr", {29'b0, ovf}, 32'd0);

    // 5: scale-1 word counter wraps after a full frame
    step(3'b000, 0, 0, 0, 1, 0, 1);
    idle(4, 1);
    clear_log();
    for (int w = 0; w < 19201; w++)
      for (int i = 0; i < 4; i++) step(3'b001, 8'($urandom), 0, 0, 0, 0, 1);
    idle(10, 1);
    check("t5_count", log_addr.size(), 19201);
    if (log_addr.size() == 19201) begin
      check("t5_last", log_addr[19199], 19199);
      check("t5_wrap", log_addr[19200], 0);
    end

    // Random phase
    ack_pct = 75;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] stb;
      if (c % 200 == 0) ack_pct = ($urandom_range(0, 1) != 0) ? 80 : 20;
      stb[0] = ($urandom_range(0, 99) < 50);
      stb[1] = ($urandom_range(0, 99) < 25);
      stb[2] = ($urandom_range(0, 99) < 12);
      step(stb, 8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 299) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < ack_pct));
    end
    idle(20, 1);
    for (int s = 0; s < 3; s++) check("rand_drained", m_n[s], 0);

    // 6: reset during an outstanding request
    for (int i = 0; i < 4; i++) step(3'b001, 8'h90 + 8'(i), 0, 0, 1'(i == 0), 0, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      idle(1, 0);
      if (wr_req) seen = 1;
    end
    check("t6_req_seen", {31'b0, seen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_req", {31'b0, wr_req}, 32'd0);
    check("t6_async_ovf", {29'b0, ovf}, 32'd0);
    model_reset();
    @(negedge tm3_clk_v0);
    @(negedge tm3_clk_v0);
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) step(3'b001, 8'hE0 + 8'(i), 0, 0, 0, 0, 1);
    idle(8, 1);
    check("t6_count", log_addr.size(), 1);
    if (log_addr.size() >= 1) begin
      check("t6_addr", log_addr[0], 0);
      check("t6_data", log_data[0], 32'hE3E2E1E0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
